id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the 32-bit MIPS pipeline. It captures the two register-file read operands, the immediate and the decoded control bundle at the end of decode, and presents them to the execute stage one cycle later. It also applies a writeback-to-decode bypass, detects load-use hazards (stalling IF/ID and inserting a bubble), and honours branch flushes. A saturating stall counter is kept for performance debug.

## Interface
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register index width
- CTRL_W, 12, control bundle width; bit0 reg_write, bit1 mem_read, bit2 reg_dst, remaining bits opaque (passed through)
- clock  in  1  pipeline clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  source/dest register indices
- id_uses_rt  in  1  instruction reads rt as a source
- id_a, id_b  in  DATA_W  register-file outputs for rs, rt
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- wb_we  in  1  writeback write enable (same signal that drives the register-file write port)
- wb_wrreg  in  REG_AW  writeback destination index
- wb_data  in  DATA_W  writeback data
- flush  in  1  branch taken in EX; squash the instruction entering EX
- stall_if  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_a, ex_b, ex_imm  out  DATA_W  registered operands/immediate
- ex_rs, ex_rt, ex_dest  out  REG_AW  registered indices; ex_dest = selected destination
- stall_count  out  16  saturating count of load-use stall cycles

## Operation
- Bypass (combinational): op_a = wb_data if wb_we && wb_wrreg != 0 && wb_wrreg == id_rs, else id_a. op_b is the same with id_rt. Register 0 is never bypassed.
- Destination: dest = id_ctrl[2] ? id_rd : id_rt.
- Hazard (combinational): hazard = id_valid && ex_valid && ex_ctrl[1] && ex_dest != 0 && (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt)).
- stall_if = hazard && !flush.
- Rising edge, priority order:
  - flush: bubble (ex_valid=0, ex_ctrl=0, ex_dest=0); data/index fields hold.
  - hazard: bubble as above; stall_count increments unless it is 0xFFFF.
  - otherwise: load ex_valid=id_valid, ex_ctrl=id_valid?id_ctrl:0, ex_a=op_a, ex_b=op_b, ex_imm, ex_rs, ex_rt, ex_dest=id_valid?dest:0.
- A bubble always has ex_ctrl=0, so it cannot write registers or memory.

## Timing
- Reset: every output register is 0 (ex_valid, ex_ctrl, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dest, stall_count). stall_if = 0 because ex_valid = 0. Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Latency: 1 cycle from ID inputs to EX outputs.
- A load-use hazard produces exactly 1 stall cycle. After that cycle the bubble has ex_valid=0, so the hazard clears and the held instruction loads on the next edge.
- stall_if is combinational from the registered EX state and the current ID inputs. It is valid before the rising edge.
- Flush together with hazard: flush wins, stall_if=0, and the counter does not increment.
- Bypass in the same cycle as writeback covers regfile write/read ordering. wb_wrreg=0 is ignored.
- stall_count saturates at 0xFFFF and does not wrap.

## Test plan
- Reset: assert reset_n=0 mid-stream with ex_valid=1 -> all outputs 0 asynchronously, stall_if=0, and the first instruction loads on the first edge after release.
- Passthrough: id_valid=1, id_a=5, id_b=7, id_imm=0xFFFF_FFFC, ctrl reg_dst=1, rd=9 -> next cycle ex_a=5, ex_b=7, ex_imm=0xFFFF_FFFC, ex_dest=9, ex_valid=1.
- Bypass: id_rs=3, id_a=0, wb_we=1, wb_wrreg=3, wb_data=0x1234 -> ex_a=0x1234. Repeat with id_rs=0, wb_wrreg=0 -> ex_a=id_a.
- Load-use: lw r4 in EX (mem_read=1, ex_dest=4), then add r5,r4,r1 in ID -> stall_if=1 for 1 cycle, a bubble enters EX, the add enters EX the following cycle, and stall_count=1. With id_uses_rt=0 and rt=4, there is no stall.
- Flush + hazard in the same cycle -> stall_if=0, ex_valid=0, ex_ctrl=0, stall_count unchanged.
- Saturation: force 0x10000+ hazard cycles -> stall_count holds 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit MIPS pipeline: writeback bypass into the
// captured operands, load-use hazard detection with bubble insertion, branch flush.
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int CTRL_W      = 12,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   id_valid_i,
    input  logic [REG_AW-1:0]      id_rs_i,
    input  logic [REG_AW-1:0]      id_rt_i,
    input  logic [REG_AW-1:0]      id_rd_i,
    input  logic                   id_uses_rt_i,
    input  logic [DATA_W-1:0]      id_a_i,
    input  logic [DATA_W-1:0]      id_b_i,
    input  logic [DATA_W-1:0]      id_imm_i,
    input  logic [CTRL_W-1:0]      id_ctrl_i,
    input  logic                   wb_we_i,
    input  logic [REG_AW-1:0]      wb_wrreg_i,
    input  logic [DATA_W-1:0]      wb_data_i,
    input  logic                   flush_i,
    output logic                   stall_if_o,
    output logic                   ex_valid_o,
    output logic [CTRL_W-1:0]      ex_ctrl_o,
    output logic [DATA_W-1:0]      ex_a_o,
    output logic [DATA_W-1:0]      ex_b_o,
    output logic [DATA_W-1:0]      ex_imm_o,
    output logic [REG_AW-1:0]      ex_rs_o,
    output logic [REG_AW-1:0]      ex_rt_o,
    output logic [REG_AW-1:0]      ex_dest_o,
    output logic [STALL_CNT_W-1:0] stall_count_o
);

    localparam int CTRL_MEM_READ = 1;
    localparam int CTRL_REG_DST  = 2;

    logic                   ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0]      ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0]      ex_a_q, ex_a_d;
    logic [DATA_W-1:0]      ex_b_q, ex_b_d;
    logic [DATA_W-1:0]      ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0]      ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0]      ex_rt_q, ex_rt_d;
    logic [REG_AW-1:0]      ex_dest_q, ex_dest_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [DATA_W-1:0] rf_val [2];
    logic [REG_AW-1:0] src_reg [2];
    logic [DATA_W-1:0] op_val [2];
    logic [REG_AW-1:0] dest;
    logic              hazard;

    assign rf_val[0]  = id_a_i;
    assign rf_val[1]  = id_b_i;
    assign src_reg[0] = id_rs_i;
    assign src_reg[1] = id_rt_i;

    // Writeback lands in the regfile at the same edge we capture, so forward it here.
    // Register 0 is hard-wired to zero and must never pick up forwarded data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            assign op_val[gi] = (wb_we_i && (wb_wrreg_i != '0) && (wb_wrreg_i == src_reg[gi]))
                                ? wb_data_i : rf_val[gi];
        end
    endgenerate

    assign dest = id_ctrl_i[CTRL_REG_DST] ? id_rd_i : id_rt_i;

    assign hazard = id_valid_i && ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_dest_q != '0)
                    && ((ex_dest_q == id_rs_i) || (id_uses_rt_i && (ex_dest_q == id_rt_i)));

    assign stall_if_o = hazard && !flush_i;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;
        ex_imm_d    = ex_imm_q;
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        ex_dest_d   = ex_dest_q;
        stall_cnt_d = stall_cnt_q;

        if (flush_i) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_dest_d  = '0;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_dest_d  = '0;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else begin
            ex_valid_d = id_valid_i;
            ex_ctrl_d  = id_valid_i ? id_ctrl_i : '0;
            ex_a_d     = op_val[0];
            ex_b_d     = op_val[1];
            ex_imm_d   = id_imm_i;
            ex_rs_d    = id_rs_i;
            ex_rt_d    = id_rt_i;
            ex_dest_d  = id_valid_i ? dest : '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_dest_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_dest_q   <= ex_dest_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_ctrl_o     = ex_ctrl_q;
    assign ex_a_o        = ex_a_q;
    assign ex_b_o        = ex_b_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_rs_o       = ex_rs_q;
    assign ex_rt_o       = ex_rt_q;
    assign ex_dest_o     = ex_dest_q;
    assign stall_count_o = stall_cnt_q;

endmodule
